// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: one full-adder slice walks the operands LSB first, the carry lives in
// a register between cycles, and {cout,sum} is published once after the final bit.
module serial_adder_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic             slice_s;
  logic             slice_c;
  logic             last_bit;
  logic [WIDTH-1:0] sum_sh_next;

  // Full-adder slice plus the MSB-side shift of its sum bit into the partial result.
  always_comb begin
    slice_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    slice_c     = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    sum_sh_next = (sum_sh_q >> 1) | ({{(WIDTH - 1){1'b0}}, slice_s} << (WIDTH - 1));
    last_bit    = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_sh_next;
          carry_q  <= slice_c;
          cnt_q    <= cnt_q + CNT_W'(1);
          // sum/cout only ever move here, so consumers never see a partial result.
          if (last_bit) begin
            sum     <= sum_sh_next;
            cout    <= slice_c;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

endmodule
